// File: rtl/nn_batch_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nn_batch_eval_ctrl
// Purpose  : Streams binary-pixel images from RAM into the MNIST core and
//            scores each prediction against a label RAM over a batch.
// Revision : 1.0  initial release
// ============================================================================
module nn_batch_eval_ctrl #(
    parameter int N_PIXELS = 784,
    parameter int N_IMAGES = 1000,
    parameter int PIX_AW   = 20,
    parameter int IMG_AW   = 10,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              pix_rd_en,
    output logic [PIX_AW-1:0] pix_addr,
    input  logic              pix_rd_data,
    output logic [IMG_AW-1:0] lbl_addr,
    input  logic [3:0]        lbl_data,
    output logic              nn_data_in,
    output logic              nn_valid_in,
    input  logic              nn_valid_out,
    input  logic [3:0]        nn_prediction,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic              last_hit,
    output logic [3:0]        last_pred,
    output logic [IMG_AW-1:0] img_count,
    output logic [IMG_AW-1:0] hit_count,
    output logic [IMG_AW-1:0] timeout_count,
    output logic              proto_err
);

    localparam int                c_PCW        = $clog2(N_PIXELS + 1);
    localparam int                c_TMW        = $clog2(TIMEOUT + 1);
    localparam logic [c_PCW-1:0]  c_PC_LAST    = c_PCW'(N_PIXELS - 1);
    localparam logic [c_TMW-1:0]  c_TM_LAST    = c_TMW'(TIMEOUT - 1);
    localparam logic [IMG_AW-1:0] c_IMG_LAST   = IMG_AW'(N_IMAGES - 1);
    localparam logic [IMG_AW-1:0] c_IMG_MAX    = IMG_AW'(N_IMAGES);
    localparam logic [PIX_AW-1:0] c_IMG_STRIDE = PIX_AW'(N_PIXELS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_DRAIN  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    logic [IMG_AW-1:0]  r_img_idx;
    logic [PIX_AW-1:0]  r_img_base;
    logic [c_PCW-1:0]   r_pc;
    logic [c_TMW-1:0]   r_timer;
    logic               r_drain;
    logic               r_rd_en_d;

    logic               w_score;
    logic               w_hit;
    logic [PIX_AW-1:0]  w_next_base;

    assign w_score     = (r_state == S_WAIT) && (nn_valid_out || (r_timer == c_TM_LAST));
    assign w_hit       = (nn_prediction == lbl_data);
    assign w_next_base = r_img_base + c_IMG_STRIDE;
    assign lbl_addr    = r_img_idx;

    function automatic logic [IMG_AW-1:0] sat_inc(input logic [IMG_AW-1:0] v);
        return (v == c_IMG_MAX) ? v : v + IMG_AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_img_idx     <= '0;
            r_img_base    <= '0;
            r_pc          <= '0;
            r_timer       <= '0;
            r_drain       <= 1'b0;
            r_rd_en_d     <= 1'b0;
            pix_rd_en     <= 1'b0;
            pix_addr      <= '0;
            nn_data_in    <= 1'b0;
            nn_valid_in   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result_valid  <= 1'b0;
            last_hit      <= 1'b0;
            last_pred     <= 4'h0;
            img_count     <= '0;
            hit_count     <= '0;
            timeout_count <= '0;
            proto_err     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            r_rd_en_d    <= pix_rd_en;
            nn_valid_in  <= r_rd_en_d;
            nn_data_in   <= r_rd_en_d & pix_rd_data;
            if (nn_valid_out && (r_state != S_WAIT)) begin
                proto_err <= 1'b1;
            end

            if (abort) begin
                r_state   <= S_IDLE;
                pix_rd_en <= 1'b0;
                r_rd_en_d <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        // Address 0 is issued on the accepting edge so the
                        // first pixel reaches the core two edges later.
                        if (start) begin
                            r_state       <= S_STREAM;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            img_count     <= '0;
                            hit_count     <= '0;
                            timeout_count <= '0;
                            proto_err     <= 1'b0;
                            r_img_idx     <= '0;
                            r_img_base    <= '0;
                            pix_rd_en     <= 1'b1;
                            pix_addr      <= '0;
                            r_pc          <= c_PCW'(1);
                        end
                    end
                    S_STREAM: begin
                        pix_rd_en <= 1'b1;
                        pix_addr  <= r_img_base + PIX_AW'(r_pc);
                        r_pc      <= r_pc + c_PCW'(1);
                        if (r_pc == c_PC_LAST) begin
                            r_state <= S_DRAIN;
                            r_drain <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        pix_rd_en <= 1'b0;
                        r_drain   <= 1'b1;
                        if (r_drain) begin
                            r_state <= S_WAIT;
                            r_timer <= '0;
                        end
                    end
                    S_WAIT: begin
                        r_timer <= r_timer + c_TMW'(1);
                        if (w_score) begin
                            result_valid <= 1'b1;
                            img_count    <= sat_inc(img_count);
                            // A result arriving on the expiry cycle still counts.
                            if (nn_valid_out) begin
                                last_hit  <= w_hit;
                                last_pred <= nn_prediction;
                                if (w_hit) begin
                                    hit_count <= sat_inc(hit_count);
                                end
                            end else begin
                                last_hit      <= 1'b0;
                                last_pred     <= 4'hF;
                                timeout_count <= sat_inc(timeout_count);
                            end
                            if (r_img_idx == c_IMG_LAST) begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_state    <= S_STREAM;
                                r_img_idx  <= r_img_idx + IMG_AW'(1);
                                r_img_base <= w_next_base;
                                pix_rd_en  <= 1'b1;
                                pix_addr   <= w_next_base;
                                r_pc       <= c_PCW'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_batch_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_batch_eval_ctrl
// Purpose  : Scoreboard bench: RAM models, core stub and result monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_nn_batch_eval_ctrl;

    localparam int c_NPIX  = 784;
    localparam int c_NIMG  = 2;
    localparam int c_PAW   = 11;
    localparam int c_IAW   = 4;
    localparam int c_TOUT  = 16;
    localparam int c_TOTAL = c_NPIX * c_NIMG;

    typedef struct packed {
        logic             hit;
        logic [3:0]       pred;
        logic [c_IAW-1:0] img;
        logic [c_IAW-1:0] hc;
        logic [c_IAW-1:0] tc;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pix_rd_en;
    logic [c_PAW-1:0] pix_addr;
    logic             pix_rd_data = 1'b0;
    logic [c_IAW-1:0] lbl_addr;
    logic [3:0]       lbl_data = 4'h0;
    logic             nn_data_in;
    logic             nn_valid_in;
    logic             nn_valid_out = 1'b0;
    logic [3:0]       nn_prediction = 4'h0;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic             last_hit;
    logic [3:0]       last_pred;
    logic [c_IAW-1:0] img_count;
    logic [c_IAW-1:0] hit_count;
    logic [c_IAW-1:0] timeout_count;
    logic             proto_err;

    nn_batch_eval_ctrl #(
        .N_PIXELS(c_NPIX), .N_IMAGES(c_NIMG), .PIX_AW(c_PAW),
        .IMG_AW(c_IAW), .TIMEOUT(c_TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_rd_data(pix_rd_data),
        .lbl_addr(lbl_addr), .lbl_data(lbl_data),
        .nn_data_in(nn_data_in), .nn_valid_in(nn_valid_in),
        .nn_valid_out(nn_valid_out), .nn_prediction(nn_prediction),
        .busy(busy), .done(done), .result_valid(result_valid),
        .last_hit(last_hit), .last_pred(last_pred), .img_count(img_count),
        .hit_count(hit_count), .timeout_count(timeout_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    logic       mem [0:2047];
    logic [3:0] labels [0:15];

    always @(posedge clk) begin
        if (pix_rd_en) pix_rd_data <= mem[pix_addr];
        lbl_data <= labels[lbl_addr];
    end

    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    res_t mon_e;

    int   exp_addr = 0, addr_err = 0, zero_err = 0;
    int   stub_img = 0, stub_pix = 0, stub_derr = 0, resp_img = 0, cd = 0;
    bit   stub_prev = 1'b0, stub_quiet = 1'b0, no_resp_img1 = 1'b0, inj_req = 1'b0;
    logic [3:0] stub_pred = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address sequence monitor
    always @(negedge clk) begin
        if (rst_n && pix_rd_en) begin
            if (pix_addr !== c_PAW'(exp_addr)) addr_err++;
            exp_addr++;
        end
    end

    // Result scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (exp_q.size() == 0) begin
                check("result_unexpected", 32'(result_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'({last_hit, last_pred, img_count, hit_count, timeout_count}),
                      32'(mon_e));
            end
        end
    end

    // Core stub: consumes pixels, answers ~10 cycles after the last one
    initial begin
        forever begin
            @(negedge clk);
            nn_valid_out = 1'b0;
            if (nn_valid_in) begin
                if (nn_data_in !== mem[(stub_img * c_NPIX + stub_pix) % 2048]) stub_derr++;
                stub_pix++;
            end else if (nn_data_in !== 1'b0) begin
                zero_err++;
            end
            if (stub_prev && !nn_valid_in && !stub_quiet) begin
                check("img_pixels", 32'(stub_pix), 32'(c_NPIX));
                check("img_data", 32'(stub_derr), 32'd0);
                resp_img  = stub_img;
                stub_img++;
                stub_pix  = 0;
                stub_derr = 0;
                cd        = 10;
            end
            stub_prev = nn_valid_in;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !stub_quiet && !(no_resp_img1 && resp_img == 1)) begin
                    nn_valid_out  = 1'b1;
                    nn_prediction = stub_pred;
                end
            end
            if (inj_req) begin
                nn_valid_out  = 1'b1;
                nn_prediction = 4'h9;
                inj_req       = 1'b0;
            end
        end
    end

    task automatic setup(input int pattern, input logic [3:0] l0, input logic [3:0] l1,
                         input logic [3:0] pred, input bit noresp);
        for (int a = 0; a < 2048; a++)
            mem[a] = (pattern == 0) ? 1'b1 : ((a % 3 == 0) != (((a >> 4) & 1) == 1));
        labels[0] = l0;  labels[1] = l1;
        stub_pred = pred; no_resp_img1 = noresp;
        stub_img = 0; stub_pix = 0; stub_derr = 0; cd = 0; stub_quiet = 1'b0;
        exp_addr = 0; addr_err = 0; zero_err = 0;
    endtask

    task automatic push_exp(input logic h, input logic [3:0] p, input int i, input int hc, input int tc);
        res_t e;
        e.hit = h; e.pred = p; e.img = c_IAW'(i); e.hc = c_IAW'(hc); e.tc = c_IAW'(tc);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_batch(input int hc, input int tc, input logic [3:0] lp);
        int n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("done", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("img_count", 32'(img_count), 32'd2);
        check("hit_count", 32'(hit_count), 32'(hc));
        check("timeout_count", 32'(timeout_count), 32'(tc));
        check("last_pred", 32'(last_pred), 32'(lp));
        repeat (3) @(posedge clk);
        #1;
        check("addr_count", 32'(exp_addr), 32'(c_TOTAL));
        check("addr_err", 32'(addr_err), 32'd0);
        check("data_idle_zero", 32'(zero_err), 32'd0);
        check("done_held", 32'(done), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid_in", 32'(nn_valid_in), 32'd0);
        check("rst_rd_en", 32'(pix_rd_en), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_img_count", 32'(img_count), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // All-ones pixels, both labels match; start latency checked
        setup(0, 4'd1, 4'd1, 4'd1, 1'b0);
        push_exp(1'b1, 4'd1, 1, 1, 0);
        push_exp(1'b1, 4'd1, 2, 2, 0);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_in_E0", 32'(nn_valid_in), 32'd0);
        check("first_addr", 32'(pix_addr), 32'd0);
        @(posedge clk); #1;
        check("valid_in_E1", 32'(nn_valid_in), 32'd0);
        @(posedge clk); #1;
        check("valid_in_E2", 32'(nn_valid_in), 32'd1);
        finish_batch(2, 0, 4'd1);

        // Patterned pixels, second label mismatches
        setup(1, 4'd1, 4'd7, 4'd1, 1'b0);
        push_exp(1'b1, 4'd1, 1, 1, 0);
        push_exp(1'b0, 4'd1, 2, 1, 0);
        pulse_start();
        finish_batch(1, 0, 4'd1);

        // Core never answers image 1
        setup(1, 4'd3, 4'd3, 4'd3, 1'b1);
        push_exp(1'b1, 4'd3, 1, 1, 0);
        push_exp(1'b0, 4'hF, 2, 1, 1);
        pulse_start();
        finish_batch(1, 1, 4'hF);

        // Spurious result strobe during STREAM
        setup(0, 4'd1, 4'd1, 4'd1, 1'b0);
        push_exp(1'b1, 4'd1, 1, 1, 0);
        push_exp(1'b1, 4'd1, 2, 2, 0);
        pulse_start();
        n = 0;
        while (stub_pix < 100 && n < 1000) begin @(posedge clk); #1; n++; end
        inj_req = 1'b1;
        finish_batch(2, 0, 4'd1);
        check("proto_err_set", 32'(proto_err), 32'd1);

        // Abort mid-image, new start clears proto_err
        setup(1, 4'd2, 4'd2, 4'd2, 1'b0);
        pulse_start();
        check("proto_err_cleared", 32'(proto_err), 32'd0);
        n = 0;
        while (!(pix_rd_en && pix_addr == c_PAW'(300)) && n < 1000) begin @(posedge clk); #1; n++; end
        check("abort_reached_300", 32'(pix_addr), 32'd300);
        stub_quiet = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(pix_rd_en), 32'd0);
        @(posedge clk); #1;
        check("abort_valid_in", 32'(nn_valid_in), 32'd0);
        check("abort_img_count", 32'(img_count), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        setup(1, 4'd2, 4'd2, 4'd2, 1'b0);
        push_exp(1'b1, 4'd2, 1, 1, 0);
        push_exp(1'b1, 4'd2, 2, 2, 0);
        pulse_start();
        finish_batch(2, 0, 4'd2);

        // Reset asserted while waiting for the core
        setup(0, 4'd1, 4'd1, 4'd1, 1'b0);
        pulse_start();
        n = 0;
        while (!nn_valid_in && n < 100) begin @(posedge clk); #1; n++; end
        while (nn_valid_in && n < 2000) begin @(posedge clk); #1; n++; end
        stub_quiet = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid_in", 32'(nn_valid_in), 32'd0);
        check("mid_rst_outputs",
              32'({done, pix_rd_en, result_valid, last_hit, last_pred, img_count, proto_err}), 32'd0);
        check("mid_rst_addr", 32'(pix_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        setup(0, 4'd1, 4'd1, 4'd1, 1'b0);
        push_exp(1'b1, 4'd1, 1, 1, 0);
        push_exp(1'b1, 4'd1, 2, 2, 0);
        pulse_start();
        finish_batch(2, 0, 4'd1);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nn_batch_eval_ctrl.md
Name: nn_batch_eval_ctrl

Overview:
Hardware batch-evaluation sequencer for the binary-pixel MNIST inference core (`top`). It streams each image from a synchronous pixel RAM into the core, one bit per cycle, then waits for the core's prediction. It scores the prediction against a label RAM and accumulates hit, miss and timeout counts over a batch of N_IMAGES. It replaces the simulation-only streaming loop and makes on-chip accuracy measurement possible.

Parameters:
N_PIXELS, 784, pixels per image (one bit each)
N_IMAGES, 1000, images per batch
PIX_AW, 20, pixel RAM address width (must satisfy 2^PIX_AW >= N_PIXELS*N_IMAGES)
IMG_AW, 10, image index / counter width
TIMEOUT, 4096, maximum cycles in WAIT before the image is declared timed out

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a batch from IDLE or DONE
abort  in  1  synchronous abort; returns to IDLE
pix_rd_en  out  1  pixel RAM read enable
pix_addr  out  PIX_AW  pixel RAM address
pix_rd_data  in  1  pixel RAM data, valid the cycle after pix_rd_en
lbl_addr  out  IMG_AW  label RAM address (= current image index)
lbl_data  in  4  label, valid 1 cycle after lbl_addr changes
nn_data_in  out  1  pixel to core (drives top.data_in)
nn_valid_in  out  1  pixel valid to core
nn_valid_out  in  1  core result strobe
nn_prediction  in  4  core predicted digit
busy  out  1  batch in progress
done  out  1  batch complete; held until next start or reset
result_valid  out  1  one-cycle pulse per scored image
last_hit  out  1  scored image was correct
last_pred  out  4  scored prediction (4'hF on timeout)
img_count  out  IMG_AW  images scored so far
hit_count  out  IMG_AW  correct predictions
timeout_count  out  IMG_AW  images that timed out
proto_err  out  1  sticky: nn_valid_out seen outside WAIT

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset drives all outputs and counters to 0 and the FSM to IDLE, including mid-batch. nn_valid_in drops the same instant.
- FSM states: IDLE, STREAM, DRAIN, WAIT, DONE.
- IDLE/DONE → STREAM on start (abort low):
  - Clears img_count, hit_count, timeout_count, proto_err and done.
  - Sets image index to 0 and pixel counter pc to 0.
  - start is ignored in STREAM, DRAIN and WAIT.
- STREAM:
  - pix_rd_en=1 and pix_addr = img_idx*N_PIXELS + pc, registered.
  - pc increments each cycle; at pc = N_PIXELS-1 go to DRAIN.
  - No stalls: the core accepts one pixel per cycle.
- Pixel pipeline: rd_en delayed one cycle (rd_en_d); nn_data_in <= pix_rd_data and nn_valid_in <= rd_en_d, both registered.
  - If start is accepted at edge E0, nn_valid_in is high E2..E(N_PIXELS+1) inclusive: exactly N_PIXELS contiguous cycles.
  - nn_data_in is 0 whenever nn_valid_in is 0.
- DRAIN: 2 cycles to flush the pipeline, then WAIT.
- WAIT: timer counts from 0.
  - nn_valid_out=1: score the image. last_hit = (nn_prediction == lbl_data); last_pred = nn_prediction; hit_count += last_hit; img_count += 1; result_valid pulses next cycle.
  - Timer reaches TIMEOUT-1 without nn_valid_out: score as a miss. last_pred=4'hF, last_hit=0, timeout_count += 1, img_count += 1, result_valid pulses.
  - After scoring: if img_idx = N_IMAGES-1 go to DONE (busy=0, done=1). Otherwise img_idx += 1, pc=0, and go straight to STREAM with no gap cycle.
- nn_valid_out in IDLE, STREAM, DRAIN or DONE: ignored for scoring; sets proto_err (sticky until the next start or reset).
- nn_valid_out on the same cycle as the timer expiring: treated as a valid result, not a timeout.
- abort (priority over start): FSM → IDLE next cycle.
  - pix_rd_en and rd_en_d clear, so nn_valid_in is 0 from the following cycle.
  - Counters hold their values; busy=0, done=0.
- busy = 1 in STREAM, DRAIN and WAIT; it is registered and asserts the cycle after start is accepted.
- Counter widths: counters saturate at N_IMAGES, which fits IMG_AW; no wrap-around. pix_addr arithmetic is unsigned at PIX_AW width.

Test Plan:
- N_IMAGES=2, all pixels 1, labels {1,1}, core stub returns 1 ten cycles after its last valid pixel → 784 contiguous nn_valid_in per image, pix_addr 0..1567, two result_valid pulses, hit_count=2, img_count=2, done=1, busy=0.
- Labels {1,7}, stub always returns 1 → image 0 last_hit=1, image 1 last_hit=0, hit_count=1, done=1.
- TIMEOUT=16, stub never responds on image 1 → timeout_count=1, last_pred=4'hF, img_count=2, done=1 (no hang).
- Stub pulses nn_valid_out during STREAM of image 0 → proto_err=1, hit_count unaffected, stream continues; next start clears proto_err.
- abort at pc=300 of image 0 → nn_valid_in low within 2 cycles, state IDLE, busy=0, img_count=0; a subsequent start restarts at pix_addr 0.
- rst_n low mid-WAIT, then released, then start → all outputs 0 during reset; full batch completes normally afterwards.
